round_sequencer: RTL and testbench
==================================

ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning system clock cycles per game second.
REQ-002 SHALL have parameter PRESTART_S, default 5, meaning the pre-round countdown length in seconds; legal range 1..99.
REQ-003 SHALL have parameter ROUND_S, default 60, meaning the play-period length in seconds; legal range 1..99.
REQ-004 SHALL have port clk_100MHz  input  1  system clock, rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  synchronous request to begin a round, sampled on every rising edge.
REQ-007 SHALL have port pause  input  1  synchronous level; high freezes all timing.
REQ-008 SHALL have port abort  input  1  synchronous request to return to idle.
REQ-009 SHALL have port state  output  2  phase: 00 IDLE, 01 COUNTDOWN, 10 PLAY, 11 OVER.
REQ-010 SHALL have port tick_1Hz  output  1  one-cycle pulse per elapsed game second.
REQ-011 SHALL have port sec_tens  output  4  BCD tens digit of the seconds remaining.
REQ-012 SHALL have port sec_ones  output  4  BCD ones digit of the seconds remaining.
REQ-013 SHALL have port go  output  1  one-cycle pulse marking the start of play.
REQ-014 SHALL have port round_over  output  1  one-cycle pulse marking the end of play.

Function
REQ-015 SHALL use a prescaler that counts 0..CLK_HZ-1 on clk_100MHz; no derived clocks; all state is clocked by clk_100MHz only.
REQ-016 Prescaler SHALL advance only in COUNTDOWN or PLAY with pause low; with pause high it SHALL hold its value.
REQ-017 Prescaler SHALL clear to 0 on every entry into COUNTDOWN or PLAY and while in IDLE or OVER.
REQ-018 tick_1Hz SHALL be high for exactly one cycle when the prescaler equals CLK_HZ-1 and advances (wrapping it to 0); it SHALL NOT assert while pause is high.
REQ-019 Seconds register SHALL be 7 bits; IDLE holds PRESTART_S and OVER holds 0.
REQ-020 IDLE: start high -> COUNTDOWN on the same edge, seconds = PRESTART_S.
REQ-021 COUNTDOWN: a tick with seconds > 1 decrements seconds; a tick with seconds == 1 -> PLAY with seconds = ROUND_S.
REQ-022 PLAY: a tick with seconds > 1 decrements seconds; a tick with seconds == 1 -> OVER with seconds = 0.
REQ-023 OVER: start high -> COUNTDOWN with seconds = PRESTART_S; otherwise hold.
REQ-024 start SHALL be ignored in COUNTDOWN and PLAY.
REQ-025 abort high in any state SHALL force IDLE on the next edge with seconds = PRESTART_S; abort has priority over start, tick, and pause.
REQ-026 go SHALL be registered and high only during the first cycle of PLAY; round_over SHALL be registered and high only during the first cycle of OVER; neither SHALL assert on an abort.
REQ-027 sec_tens SHALL equal seconds/10 and sec_ones SHALL equal seconds%10, combinational from the seconds register, valid for all values 0..99.
REQ-028 Seconds SHALL never wrap below 0.

Reset
REQ-029 Asserting reset SHALL immediately force state = IDLE, prescaler = 0, seconds = PRESTART_S, and tick_1Hz = go = round_over = 0, regardless of clock.
REQ-030 Reset mid-round SHALL discard all progress; after release the block SHALL wait in IDLE for start.

Verification (bench overrides CLK_HZ=10, PRESTART_S=3, ROUND_S=12)
REQ-031 Scenario: reset, then a 1-cycle start pulse -> state=01 next edge, digits 0/3; ticks every 10 cycles; digits 0/2, 0/1, then state=10, digits 1/2, go high for 1 cycle.
REQ-032 Scenario: let PLAY run 12 ticks -> digits count 12..1, then state=11, digits 0/0, round_over high for exactly 1 cycle; state holds at 11 with no further ticks.
REQ-033 Scenario: in PLAY at prescaler=9, hold pause for 25 cycles -> no tick and digits frozen; the tick occurs on the first edge after pause drops.
REQ-034 Scenario: abort asserted in the same cycle as a terminal tick with seconds=1 in PLAY -> state=00, digits 0/3, no round_over.
REQ-035 Scenario: start pulsed during COUNTDOWN and during PLAY -> no effect; start in OVER -> state=01, digits 0/3.
REQ-036 Scenario: asynchronous reset between clock edges mid-PLAY -> outputs reach reset values before the next edge.

Source files
------------

// File: rtl/round_sequencer.sv
// Game round sequencer: idle -> pre-round countdown -> timed play -> over, with a 1 Hz game tick.
// Remaining seconds are presented as two BCD digits; pause freezes all timing, abort returns to idle.
module round_sequencer #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int PRESTART_S = 5,
    parameter int ROUND_S    = 60
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    output logic [1:0] state,
    output logic       tick_1Hz,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       go,
    output logic       round_over
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [6:0]    SEC_PRE    = 7'(PRESTART_S);
    localparam logic [6:0]    SEC_ROUND  = 7'(ROUND_S);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        COUNTDOWN = 2'b01,
        PLAY      = 2'b10,
        OVER      = 2'b11
    } phase_t;

    phase_t        phase, phase_next;
    logic [PW-1:0] presc, presc_next;
    logic [6:0]    seconds, seconds_next;
    logic          go_next, over_next;
    logic          running;
    logic          tick;

    assign running  = (phase == COUNTDOWN) || (phase == PLAY);
    assign tick     = running && !pause && (presc == PRESC_LAST);
    assign tick_1Hz = tick;
    assign state    = phase;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            phase      <= IDLE;
            presc      <= '0;
            seconds    <= SEC_PRE;
            go         <= 1'b0;
            round_over <= 1'b0;
        end else begin
            phase      <= phase_next;
            presc      <= presc_next;
            seconds    <= seconds_next;
            go         <= go_next;
            round_over <= over_next;
        end
    end

    always_comb begin
        phase_next   = phase;
        presc_next   = presc;
        seconds_next = seconds;
        go_next      = 1'b0;
        over_next    = 1'b0;

        // Prescaler holds while paused; a tick wraps it back to zero.
        if (running && !pause) begin
            presc_next = tick ? '0 : presc + PW'(1);
        end

        case (phase)
            IDLE: begin
                presc_next   = '0;
                seconds_next = SEC_PRE;
                if (start) begin
                    phase_next = COUNTDOWN;
                end
            end
            COUNTDOWN: begin
                if (tick) begin
                    if (seconds > 7'd1) begin
                        seconds_next = seconds - 7'd1;
                    end else begin
                        phase_next   = PLAY;
                        seconds_next = SEC_ROUND;
                        presc_next   = '0;
                        go_next      = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    if (seconds > 7'd1) begin
                        seconds_next = seconds - 7'd1;
                    end else begin
                        phase_next   = OVER;
                        seconds_next = 7'd0;
                        over_next    = 1'b1;
                    end
                end
            end
            default: begin
                presc_next   = '0;
                seconds_next = 7'd0;
                if (start) begin
                    phase_next   = COUNTDOWN;
                    seconds_next = SEC_PRE;
                end
            end
        endcase

        // Abort overrides everything, including a terminal tick in the same cycle.
        if (abort) begin
            phase_next   = IDLE;
            presc_next   = '0;
            seconds_next = SEC_PRE;
            go_next      = 1'b0;
            over_next    = 1'b0;
        end
    end

    // Binary to BCD for 0..99 by threshold comparison.
    always_comb begin
        sec_tens = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (seconds >= 7'(i * 10)) begin
                sec_tens = 4'(i);
            end
        end
        sec_ones = 4'(seconds - 7'(sec_tens * 10));
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with a 10-cycle game second, 3 s countdown and 12 s round.
module tb_round_sequencer;

    logic       clk_100MHz;
    logic       reset;
    logic       start;
    logic       pause;
    logic       abort;
    logic [1:0] state;
    logic       tick_1Hz;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       go;
    logic       round_over;

    int n_cmp = 0;
    int n_err = 0;
    int tick_cnt = 0;
    int ro_cnt = 0;
    int snap;

    round_sequencer #(
        .CLK_HZ    (10),
        .PRESTART_S(3),
        .ROUND_S   (12)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .state     (state),
        .tick_1Hz  (tick_1Hz),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .go        (go),
        .round_over(round_over)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    // Pulses are counted on the edge that consumes them.
    always @(posedge clk_100MHz) begin
        if (tick_1Hz)   tick_cnt++;
        if (round_over) ro_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic check_digits(input string tag, input int secs);
        check({tag, "_tens"}, int'(sec_tens), secs / 10);
        check({tag, "_ones"}, int'(sec_ones), secs % 10);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        cyc(2);
        check("rst_state", int'(state), 0);
        check_digits("rst", 3);
        check("rst_tick", int'(tick_1Hz), 0);
        check("rst_go", int'(go), 0);
        check("rst_over", int'(round_over), 0);
        reset = 1'b0;
        cyc(2);

        // Countdown 3..1, with a start pulse that must be ignored
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("cd_state", int'(state), 1);
        check_digits("cd3", 3);
        cyc(9);
        check("cd_tick_hi", int'(tick_1Hz), 1);
        check_digits("cd3_late", 3);
        cyc(1);
        check("cd_tick_lo", int'(tick_1Hz), 0);
        check_digits("cd2", 2);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("cd_start_ign", int'(state), 1);
        check_digits("cd2_ign", 2);
        cyc(9);
        check_digits("cd1", 1);
        cyc(10);
        check("play_state", int'(state), 2);
        check_digits("play12", 12);
        check("go_hi", int'(go), 1);
        cyc(1);
        check("go_lo", int'(go), 0);

        // Pause at prescaler terminal count
        cyc(8);
        check("pre_pause_tick", int'(tick_1Hz), 1);
        pause = 1'b1;
        snap = tick_cnt;
        cyc(25);
        check("pause_ticks", tick_cnt - snap, 0);
        check("pause_tick_now", int'(tick_1Hz), 0);
        check_digits("pause_frozen", 12);
        pause = 1'b0;
        #1;
        check("unpause_tick", int'(tick_1Hz), 1);
        cyc(1);
        check("unpause_ticks", tick_cnt - snap, 1);
        check_digits("play11", 11);

        // Start in PLAY is ignored
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("play_start_ign", int'(state), 2);
        check_digits("play11_ign", 11);
        cyc(9);
        for (int s = 10; s >= 1; s--) begin
            check_digits($sformatf("play%0d", s), s);
            check($sformatf("play%0d_state", s), int'(state), 2);
            cyc(10);
        end
        check("over_state", int'(state), 3);
        check_digits("over", 0);
        check("over_pulse_hi", int'(round_over), 1);
        cyc(1);
        check("over_pulse_lo", int'(round_over), 0);
        check("over_pulse_cnt", ro_cnt, 1);
        snap = tick_cnt;
        cyc(30);
        check("over_hold", int'(state), 3);
        check("over_no_ticks", tick_cnt - snap, 0);

        // Start from OVER restarts the countdown
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("restart_state", int'(state), 1);
        check_digits("restart", 3);

        // Abort on the terminal PLAY tick
        cyc(30);
        check("r2_play", int'(state), 2);
        check_digits("r2_play12", 12);
        cyc(110);
        check_digits("r2_play1", 1);
        cyc(9);
        check("r2_term_tick", int'(tick_1Hz), 1);
        abort = 1'b1;
        snap = ro_cnt;
        cyc(1);
        abort = 1'b0;
        check("abort_state", int'(state), 0);
        check_digits("abort", 3);
        check("abort_over", int'(round_over), 0);
        check("abort_go", int'(go), 0);
        cyc(5);
        check("abort_over_cnt", ro_cnt - snap, 0);
        check("abort_idle_hold", int'(state), 0);

        // Asynchronous reset mid-PLAY
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(30);
        cyc(25);
        check("r3_play", int'(state), 2);
        check_digits("r3_play10", 10);
        #2;
        reset = 1'b1;
        #1;
        check("arst_state", int'(state), 0);
        check_digits("arst", 3);
        check("arst_tick", int'(tick_1Hz), 0);
        check("arst_go", int'(go), 0);
        check("arst_over", int'(round_over), 0);
        cyc(2);
        reset = 1'b0;
        cyc(20);
        check("post_rst_idle", int'(state), 0);
        check_digits("post_rst", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
